// File: rtl/alu_seq.sv
// alu_seq: single-issue signed ALU. Logic, shift and add/sub ops finish at
// the acceptance edge; MUL runs a W-cycle shift-add on operand magnitudes
// and blocks new requests until the product is registered.
module alu_seq #(
  parameter int W   = 11,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_neg,
  output logic         o_ovf
);

  typedef enum logic [2:0] {
    OP_SUB  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SRA  = 3'b101,
    OP_MUL  = 3'b110,
    OP_LOAD = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int             CW        = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST_ITER = CW'(W - 1);

  op_e op;
  assign op = op_e'(i_op);

  // Registered state
  state_e          state_q,    state_d;
  logic            valid_q,    valid_d;
  logic [W-1:0]    result_q,   result_d;
  logic            zero_q,     zero_d;
  logic            neg_q,      neg_d;
  logic            ovf_q,      ovf_d;
  logic [2*W-1:0]  acc_q,      acc_d;
  logic [2*W-1:0]  mcand_q,    mcand_d;
  logic [W-1:0]    mplier_q,   mplier_d;
  logic            prod_neg_q, prod_neg_d;
  logic [CW-1:0]   cnt_q,      cnt_d;

  // Single-cycle datapath results
  logic [W-1:0]    alu_res;
  logic            alu_ovf;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;

  // Multiplier step results
  logic [2*W-1:0]  acc_next;
  logic [2*W-1:0]  product;
  logic            prod_ovf;

  // Single-cycle ALU result, overflow flag and operand magnitudes for MUL.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    alu_res = '0;
    alu_ovf = 1'b0;
    // Magnitudes are W-bit unsigned, so the most negative operand maps to
    // 2^(W-1) without wrapping back to itself.
    a_mag = i_a[W-1] ? (~i_a + 1'b1) : i_a;
    b_mag = i_b[W-1] ? (~i_b + 1'b1) : i_b;
    case (op)
      OP_SUB: begin
        alu_res = i_a - i_b;
        alu_ovf = (i_a[W-1] != i_b[W-1]) && (alu_res[W-1] != i_a[W-1]);
      end
      OP_ADD: begin
        alu_res = i_a + i_b;
        alu_ovf = (i_a[W-1] == i_b[W-1]) && (alu_res[W-1] != i_a[W-1]);
      end
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      // Arithmetic shift sign-fills; amounts >= W leave only sign bits.
      OP_SRA:  alu_res = W'($signed(i_a) >>> i_b[SHW-1:0]);
      OP_LOAD: alu_res = i_b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add iteration plus the signed product it would give if final.
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    product  = prod_neg_q ? (~acc_next + 1'b1) : acc_next;
    // In range only when the upper bits down to the result sign all agree.
    prod_ovf = !((&product[2*W-1:W-1]) || !(|product[2*W-1:W-1]));
  end

  // Next-state and output logic for the IDLE/MUL controller.
  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_neg_d = prod_neg_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (op == OP_MUL) begin
            state_d    = S_MUL;
            acc_d      = '0;
            mcand_d    = {{W{1'b0}}, a_mag};
            mplier_d   = b_mag;
            prod_neg_d = i_a[W-1] ^ i_b[W-1];
            cnt_d      = '0;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[W-1];
            ovf_d    = alu_ovf;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          result_d = product[W-1:0];
          zero_d   = (product[W-1:0] == '0);
          neg_d    = product[W-1];
          ovf_d    = prod_ovf;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_neg_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_neg_q <= prod_neg_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_zero   = zero_q;
  assign o_neg    = neg_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at W=11.
module tb_alu_seq;

  localparam int W = 11;

  localparam logic [2:0] SUB  = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] AND_ = 3'b010;
  localparam logic [2:0] OR_  = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100;
  localparam logic [2:0] SRA  = 3'b101;
  localparam logic [2:0] MUL  = 3'b110;
  localparam logic [2:0] LOAD = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [2:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic         o_zero;
  logic         o_neg;
  logic         o_ovf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_neg    (o_neg),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return 32'(t);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; sampling and driving happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input int a, input int b);
    i_valid = v;
    i_op    = op;
    i_a     = a[W-1:0];
    i_b     = b[W-1:0];
  endtask

  task automatic check_out(input string tag, input int res, input logic z, input logic n, input logic o);
    check({tag, ".valid"},  32'(o_valid),  32'd1);
    check({tag, ".result"}, 32'(o_result), r(res));
    check({tag, ".zero"},   32'(o_zero),   32'(z));
    check({tag, ".neg"},    32'(o_neg),    32'(n));
    check({tag, ".ovf"},    32'(o_ovf),    32'(o));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ready"},  32'(o_ready),  32'd1);
    check({tag, ".valid"},  32'(o_valid),  32'd0);
    check({tag, ".result"}, 32'(o_result), 32'd0);
    check({tag, ".zero"},   32'(o_zero),   32'd1);
    check({tag, ".neg"},    32'(o_neg),    32'd0);
    check({tag, ".ovf"},    32'(o_ovf),    32'd0);
  endtask

  // Accept a MUL, idle through the busy window, then check the result cycle.
  task automatic run_mul(input string tag, input int a, input int b, input int res,
                         input logic z, input logic n, input logic o);
    drive(1'b1, MUL, a, b);
    tick();
    drive(1'b0, ADD, 0, 0);
    repeat (W) tick();
    check_out(tag, res, z, n, o);
    check({tag, ".ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin : stim
    logic seen_valid;
    rst_n = 1'b0;
    drive(1'b0, ADD, 0, 0);
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset("reset");

    // ADD overflow into the most negative value.
    drive(1'b1, ADD, 1023, 1);
    tick();
    check_out("add_ovf", -1024, 1'b0, 1'b1, 1'b1);
    drive(1'b0, ADD, 0, 0);
    tick();
    check("add_ovf.pulse", 32'(o_valid), 32'd0);
    check("add_ovf.hold", 32'(o_result), r(-1024));

    // Back-to-back SUB then ADD.
    drive(1'b1, SUB, 5, 5);
    tick();
    check_out("sub_zero", 0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, ADD, -3, 2);
    tick();
    check_out("add_neg", -1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, SUB, -1024, 1);
    tick();
    check_out("sub_ovf", 1023, 1'b0, 1'b0, 1'b1);
    drive(1'b1, AND_, 12, 10);
    tick();
    check_out("and", 8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OR_, 12, 10);
    tick();
    check_out("or", 14, 1'b0, 1'b0, 1'b0);
    drive(1'b1, XOR_, -1, 1023);
    tick();
    check_out("xor", -1024, 1'b0, 1'b1, 1'b0);
    drive(1'b1, SRA, -1024, 3);
    tick();
    check_out("sra3", -128, 1'b0, 1'b1, 1'b0);
    drive(1'b1, SRA, -1024, 15);
    tick();
    check_out("sra15", -1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, SRA, -1024, 19);
    tick();
    check_out("sra_lowbits", -128, 1'b0, 1'b1, 1'b0);
    drive(1'b1, SRA, 100, 2);
    tick();
    check_out("sra_pos", 25, 1'b0, 1'b0, 1'b0);
    drive(1'b1, LOAD, 1023, -7);
    tick();
    check_out("load", -7, 1'b0, 1'b1, 1'b0);
    drive(1'b0, ADD, 0, 0);
    tick();
    check("load.pulse", 32'(o_valid), 32'd0);

    // MUL -3*7 with a stray request held high through the busy window.
    drive(1'b1, MUL, -3, 7);
    tick();
    drive(1'b1, ADD, 100, 100);
    for (int i = 1; i <= W; i++) begin
      check($sformatf("mul_busy%0d.ready", i), 32'(o_ready), 32'd0);
      check($sformatf("mul_busy%0d.valid", i), 32'(o_valid), 32'd0);
      tick();
    end
    check_out("mul_m3x7", -21, 1'b0, 1'b1, 1'b0);
    check("mul_m3x7.ready", 32'(o_ready), 32'd1);
    drive(1'b0, ADD, 0, 0);
    tick();
    check("mul_m3x7.pulse", 32'(o_valid), 32'd0);
    check("mul_m3x7.hold", 32'(o_result), r(-21));

    run_mul("mul_64x32",   64,    32,  0,     1'b1, 1'b0, 1'b1);
    run_mul("mul_min_x1",  -1024, 1,   -1024, 1'b0, 1'b1, 1'b0);
    run_mul("mul_min_xm1", -1024, -1,  -1024, 1'b0, 1'b1, 1'b1);
    run_mul("mul_31x33",   31,    33,  1023,  1'b0, 1'b0, 1'b0);
    run_mul("mul_m32x32",  -32,   32,  -1024, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a MUL, with a competing request on the reset edge.
    drive(1'b1, MUL, 5, 9);
    tick();
    drive(1'b0, ADD, 0, 0);
    repeat (4) tick();
    check("abort.busy", 32'(o_ready), 32'd0);
    rst_n = 1'b0;
    drive(1'b1, ADD, 7, 7);
    tick();
    rst_n = 1'b1;
    drive(1'b0, ADD, 0, 0);
    check_reset("abort");
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid) seen_valid = 1'b1;
    end
    check("abort.no_valid", 32'(seen_valid), 32'd0);
    check("abort.ready", 32'(o_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 11: operand/result width in bits, two's-complement signed, legal range 4..32.
REQ-002 Parameter SHW, default $clog2(W): number of B low bits used as shift amount.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port i_valid  input  1: operation request, qualified by o_ready.
REQ-006 Port i_op  input  3: opcode.
REQ-007 Port i_a  input  W: signed operand A.
REQ-008 Port i_b  input  W: signed operand B.
REQ-009 Port o_ready  output  1: block can accept a request this cycle.
REQ-010 Port o_valid  output  1: one-cycle pulse; o_result and flags are new.
REQ-011 Port o_result  output  W: registered signed result, held until next o_valid.
REQ-012 Port o_zero / o_neg / o_ovf  output  1 each: registered flags, held with o_result.

Function
REQ-013 Opcodes SHALL be: 000 SUB A-B; 001 ADD A+B; 010 AND; 011 OR; 100 XOR; 101 SRA A by B[SHW-1:0]; 110 MUL A*B signed; 111 LOAD (result=B).
REQ-014 Request SHALL be accepted only on a cycle with i_valid=1 and o_ready=1; operands and opcode captured at that edge.
REQ-015 FSM SHALL have states IDLE and MUL; o_ready=1 exactly when state=IDLE.
REQ-016 Non-MUL op accepted in IDLE SHALL register result/flags at the acceptance edge, o_valid=1 the following cycle, state stays IDLE (back-to-back ops every cycle).
REQ-017 MUL accepted in IDLE SHALL enter MUL, perform W shift-add iterations (one per cycle) on |A|,|B|, negate the 2W-bit product if signs differ, register low W bits on the edge ending iteration W, return to IDLE.
REQ-018 MUL latency: o_valid high exactly W+1 cycles after the acceptance edge; o_ready low for W cycles.
REQ-019 i_valid while o_ready=0 SHALL be ignored (no queuing).
REQ-020 ADD/SUB SHALL wrap modulo 2^W; o_ovf=1 on signed overflow (operand signs determine as usual).
REQ-021 MUL o_ovf=1 when the true product lies outside [-2^(W-1), 2^(W-1)-1]; |min| SHALL be handled as W-bit unsigned magnitude.
REQ-022 SRA SHALL sign-fill; amount >= W SHALL yield all sign bits.
REQ-023 AND/OR/XOR/SRA/LOAD SHALL set o_ovf=0.
REQ-024 o_zero = (o_result==0); o_neg = o_result[W-1]; both from the registered result, all ops.
REQ-025 o_valid SHALL be a single-cycle pulse; no backpressure from consumer.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=IDLE, o_valid=0, o_result=0, o_zero=1, o_neg=0, o_ovf=0, o_ready=1 next cycle.
REQ-027 Reset during MUL SHALL abort it with no o_valid ever issued for that op.
REQ-028 rst_n has priority over any i_valid in the same cycle.

Verification (W=11)
REQ-029 ADD A=1023 B=1 -> next cycle o_valid=1, o_result=-1024, o_neg=1, o_ovf=1, o_zero=0.
REQ-030 SUB A=5 B=5, then ADD A=-3 B=2 on consecutive cycles -> two consecutive o_valid: 0/zero=1, then -1/neg=1.
REQ-031 MUL A=-3 B=7 -> o_ready low 11 cycles, o_valid 12 cycles after acceptance, o_result=-21, o_ovf=0; i_valid during busy ignored.
REQ-032 MUL A=64 B=32 -> o_result=0, o_zero=1, o_ovf=1; MUL A=-1024 B=1 -> -1024, o_ovf=0.
REQ-033 SRA A=-1024 B=3 -> -128; B=15 -> -1; LOAD B=-7 -> -7, o_ovf=0.
REQ-034 MUL accepted, rst_n=0 at cycle 5 of iteration -> o_ready=1, all outputs at reset values, no o_valid within 20 following cycles absent new requests.
